// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / mult-div stall controller for the five-stage pipeline.
// Define HAZARD_MDU_EN to build the multi-cycle mult/div occupancy tracking.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_op,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       mdu_busy,
  output logic       mdu_done
);

  typedef enum logic [1:0] {RUN, LDSTALL, MDU, FLUSH} state_t;

  state_t state_q, state_d;
  logic   load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

`ifdef HAZARD_MDU_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_params = MULT_CYCLES + DIV_CYCLES + CNT_W;
  logic unused_inputs;
  assign unused_inputs = ^{ex_mdu_start, ex_mdu_op, unused_params[0]};
`endif

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    state_d     = state_q;
`ifdef HAZARD_MDU_EN
    cnt_d       = cnt_q;
`endif
    if (!rst_n) begin
      state_d = RUN;
`ifdef HAZARD_MDU_EN
      cnt_d   = '0;
`endif
    end else if (branch_taken) begin
      // Branch wins in every state and aborts any running mult/div silently.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = FLUSH;
`ifdef HAZARD_MDU_EN
      cnt_d       = '0;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
`ifdef HAZARD_MDU_EN
          if (ex_mdu_start) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            mdu_busy   = 1'b1;
            cnt_d      = ex_mdu_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state_d    = MDU;
          end else
`endif
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LDSTALL;
          end
        end
`ifdef HAZARD_MDU_EN
        MDU: begin
          if (cnt_q != '0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            mdu_busy   = 1'b1;
            cnt_d      = cnt_q - 1'b1;
          end else begin
            mdu_done = 1'b1;
            state_d  = RUN;
          end
        end
`endif
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
`ifdef HAZARD_MDU_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef HAZARD_MDU_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against a cycle-level model.
// The model follows HAZARD_MDU_EN the same way the design does.
module tb_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken, ex_mdu_start, ex_mdu_op;
  logic       pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, mdu_busy, mdu_done;

  int checks   = 0;
  int failures = 0;

  // Model: stall cycles still owed by a mult/div, a pending done pulse, and a one-cycle hazard mask.
  int m_rem  = 0;
  bit m_done = 1'b0;
  bit m_mask = 1'b0;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_op(ex_mdu_op),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  // Expected vector order: pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, mdu_busy, mdu_done
  localparam logic [6:0] DEF   = 7'b1110000;
  localparam logic [6:0] LDST  = 7'b0011000;
  localparam logic [6:0] BRFL  = 7'b1111100;
  localparam logic [6:0] MDUST = 7'b0000010;
  localparam logic [6:0] DONE  = 7'b1110001;

  function automatic logic [6:0] model_step();
    logic [6:0] e;
    bit hz;
    hz = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (!rst_n) begin
      e = DEF; m_rem = 0; m_done = 0; m_mask = 0;
    end else if (branch_taken) begin
      e = BRFL; m_rem = 0; m_done = 0; m_mask = 1;
    end else if (m_rem > 0) begin
      e = MDUST; m_rem--; if (m_rem == 0) m_done = 1;
    end else if (m_done) begin
      e = DONE; m_done = 0;
    end else if (m_mask) begin
      e = DEF; m_mask = 0;
    end else if (MDU_EN && ex_mdu_start) begin
      e = MDUST; m_rem = (ex_mdu_op ? DIV_N : MULT_N) - 1;
    end else if (hz) begin
      e = LDST; m_mask = 1;
    end else begin
      e = DEF;
    end
    return e;
  endfunction

  task automatic step(input bit rn, input bit mr, input int ert, input int rs, input int rt,
                      input bit ut, input bit br, input bit st, input bit op, input string tag);
    logic [6:0] exp_v, obs_v;
    rst_n = rn; ex_memread = mr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = ut; branch_taken = br; ex_mdu_start = st; ex_mdu_op = op;
    #3;
    exp_v = model_step();
    obs_v = {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, mdu_busy, mdu_done};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset with hazards on the inputs: outputs must stay at default.
    step(0, 1, 8, 8, 0, 0, 0, 0, 0, "reset_ld");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, "reset_br");
    idle(1, "post_reset");

    step(1, 1, 8, 8, 0, 0, 0, 0, 0, "lduse_c1");
    step(1, 1, 8, 8, 0, 0, 0, 0, 0, "lduse_c2");
    step(1, 1, 8, 3, 8, 1, 0, 0, 0, "lduse_rt");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "lduse_rt_after");
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, "ld_r0");
    step(1, 1, 8, 1, 8, 0, 0, 0, 0, "ld_rt_unused");

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, "mult_c1");
    for (int i = 0; i < 5; i++) step(1, 1, 8, 8, 0, 0, 0, 1, 0, "mult_run");
    idle(1, "mult_idle");

    step(1, 0, 0, 0, 0, 0, 0, 1, 1, "div_c1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "div_c2");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, "div_branch");
    step(1, 1, 8, 8, 0, 0, 0, 1, 0, "flush_masked");
    idle(DIV_N + 2, "div_abort_nodone");

    step(1, 1, 9, 9, 0, 0, 1, 0, 0, "br_and_lduse");
    step(1, 1, 9, 9, 0, 0, 0, 0, 0, "br_flush_cycle");
    idle(1, "br_idle");

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mdu_c1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mdu_c2");
    idle(MULT_N + 2, "rst_mdu_after");
    step(1, 1, 7, 7, 0, 0, 0, 0, 0, "rst_mdu_lduse");

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
